decode_stage_pipe: RTL and testbench

//  Registered ID-stage decoder for the 16-bit WISC ISA: accepts fetched instructions over a valid/ready

---
 rtl/wisc_isa_pkg.sv | 29 ++
 rtl/decode_stage_pipe_if.sv | 36 +++
 rtl/wisc_decode_comb.sv | 35 +++
 rtl/decode_stage_pipe.sv | 124 ++++++++++++
 tb/tb_decode_stage_pipe.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_isa_pkg.sv
// WISC 16-bit ISA constants and the decoded-entry record shared by the decode stage.
package wisc_isa_pkg;

  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_LLB = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Low bit of each 4-bit field in the instruction word
  localparam int OPC_LSB  = 12;
  localparam int RD_LSB   = 8;
  localparam int MID_LSB  = 4;
  localparam int LOW_LSB  = 0;
  localparam int COND_LSB = 9;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [7:0] imm8;
    logic [8:0] off9;
    logic [2:0] cond;
    logic       wmem_en;
    logic       wreg_en;
    logic       is_hlt;
  } dec_t;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-to-execute handshake bundle of the decode stage; the stage itself uses the slave view.
interface decode_stage_pipe_if #(
  parameter int PC_W  = 16,
  parameter int RF_AW = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [3:0]       out_opcode;
  logic [RF_AW-1:0] out_rd;
  logic [RF_AW-1:0] out_rs;
  logic [RF_AW-1:0] out_rt;
  logic [7:0]       out_imm8;
  logic [8:0]       out_off9;
  logic [2:0]       out_cond;
  logic             out_wmem_en;
  logic             out_wreg_en;
  logic             halted;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
           out_imm8, out_off9, out_cond, out_wmem_en, out_wreg_en, halted
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
           out_imm8, out_off9, out_cond, out_wmem_en, out_wreg_en, halted
  );
endinterface

// File: rtl/wisc_decode_comb.sv
// Purpose: pure field decode of one WISC instruction word into a dec_t record.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is captured.
module wisc_decode_comb
  import wisc_isa_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  logic [3:0] opc;
  assign opc = instr[OPC_LSB +: 4];

  always_comb begin
    dec        = '0;
    dec.opcode = opc;
    dec.rd     = instr[RD_LSB +: 4];
    // Memory-class opcodes (10xx) read the destination field as a source
    if (opc[3:2] == 2'b10) begin
      dec.rs = instr[RD_LSB +: 4];
      dec.rt = instr[MID_LSB +: 4];
    end else begin
      dec.rs = instr[MID_LSB +: 4];
      dec.rt = instr[LOW_LSB +: 4];
    end
    dec.imm8    = instr[7:0];
    dec.off9    = (opc == OP_B) ? instr[8:0] : 9'd0;
    dec.cond    = instr[COND_LSB +: 3];
    dec.wmem_en = (opc == OP_SW);
    dec.wreg_en = (instr[RD_LSB +: 4] != 4'd0) &&
                  (!((opc == OP_SW) || (opc[3:2] == 2'b11)) || (opc == OP_LLB));
    dec.is_hlt  = (opc == OP_HLT);
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Purpose: registered WISC ID stage with 2-entry skid, flush and sticky halt (perf counters under DECODE_PERF_CNT_EN).
// Latency: 1 cycle from input handshake to out_valid when the output register is free or draining.
// Backpressure: in_ready is registered; drops when the skid is full or a HLT has been accepted.
module decode_stage_pipe
  import wisc_isa_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int RF_AW = 4
`ifdef DECODE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef DECODE_PERF_CNT_EN
  output logic [CNT_W-1:0]  perf_decoded,
  output logic [CNT_W-1:0]  perf_stall,
`endif
  decode_stage_pipe_if.slave bus
);

  dec_t            in_dec;
  dec_t            out_q, skid_q;
  logic [PC_W-1:0] out_pc_q, skid_pc_q;
  logic            out_vld_q, skid_vld_q, halt_pend_q, halted_q, in_rdy_q;
  logic            accept, out_hs, out_load, skid_vld_nxt, halt_pend_nxt;

  wisc_decode_comb u_dec (
    .instr (bus.in_instr),
    .dec   (in_dec)
  );

  assign accept   = bus.in_valid && in_rdy_q && !bus.flush;
  assign out_hs   = out_vld_q && bus.out_ready;
  assign out_load = !out_vld_q || bus.out_ready;

  always_comb begin
    skid_vld_nxt = skid_vld_q;
    if (out_load) begin
      skid_vld_nxt = skid_vld_q && accept;
    end else if (accept) begin
      skid_vld_nxt = 1'b1;
    end
    halt_pend_nxt = halt_pend_q || (accept && in_dec.is_hlt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_pc_q    <= '0;
      out_vld_q   <= 1'b0;
      skid_q      <= '0;
      skid_pc_q   <= '0;
      skid_vld_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
      in_rdy_q    <= 1'b1;
    end else begin
      // A HLT leaving in a flush cycle still counts as retired
      if (out_hs && out_q.is_hlt) begin
        halted_q <= 1'b1;
      end
      if (bus.flush) begin
        out_vld_q   <= 1'b0;
        skid_vld_q  <= 1'b0;
        halt_pend_q <= 1'b0;
        in_rdy_q    <= 1'b1;
      end else begin
        skid_vld_q  <= skid_vld_nxt;
        halt_pend_q <= halt_pend_nxt;
        in_rdy_q    <= !skid_vld_nxt && !halt_pend_nxt;
        if (out_load) begin
          if (skid_vld_q) begin
            out_q     <= skid_q;
            out_pc_q  <= skid_pc_q;
            out_vld_q <= 1'b1;
          end else if (accept) begin
            out_q     <= in_dec;
            out_pc_q  <= bus.in_pc;
            out_vld_q <= 1'b1;
          end else begin
            out_vld_q <= 1'b0;
          end
        end
        // New entry parks in the skid when the output is stalled or the skid is draining into it
        if (accept && (skid_vld_q || !out_load)) begin
          skid_q    <= in_dec;
          skid_pc_q <= bus.in_pc;
        end
      end
    end
  end

`ifdef DECODE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded <= '0;
      perf_stall   <= '0;
    end else begin
      if (out_hs && !(&perf_decoded)) begin
        perf_decoded <= perf_decoded + 1'b1;
      end
      if (out_vld_q && !bus.out_ready && !(&perf_stall)) begin
        perf_stall <= perf_stall + 1'b1;
      end
    end
  end
`endif

  assign bus.in_ready    = in_rdy_q;
  assign bus.out_valid   = out_vld_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_opcode  = out_q.opcode;
  assign bus.out_rd      = RF_AW'(out_q.rd);
  assign bus.out_rs      = RF_AW'(out_q.rs);
  assign bus.out_rt      = RF_AW'(out_q.rt);
  assign bus.out_imm8    = out_q.imm8;
  assign bus.out_off9    = out_q.off9;
  assign bus.out_cond    = out_q.cond;
  assign bus.out_wmem_en = out_q.wmem_en;
  assign bus.out_wreg_en = out_q.wreg_en;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed ISA/skid/halt/flush/reset steps, then random traffic vs a queue model.
module tb_decode_stage_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_pipe_if #(.PC_W(16), .RF_AW(4)) bus ();

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded, perf_stall;
  decode_stage_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .perf_decoded (perf_decoded),
    .perf_stall   (perf_stall),
    .bus          (bus)
  );
`else
  decode_stage_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected decode computed straight from the ISA field rules
  function automatic logic [37:0] ref_dec(input logic [15:0] w);
    int unsigned x, opc, rd, mid, low, rs, rt, off, wmem, wreg;
    x    = w;
    opc  = x / 4096;
    rd   = (x / 256) % 16;
    mid  = (x / 16) % 16;
    low  = x % 16;
    if (opc / 4 == 2) begin rs = rd; rt = mid; end
    else begin rs = mid; rt = low; end
    off  = (opc == 12) ? x % 512 : 0;
    wmem = (opc == 9) ? 1 : 0;
    wreg = (rd != 0 && (!(opc == 9 || opc >= 12) || opc == 14)) ? 1 : 0;
    return {4'(opc), 4'(rd), 4'(rs), 4'(rt), 8'(x % 256), 9'(off), 3'((x / 512) % 8),
            1'(wmem), 1'(wreg)};
  endfunction

  function automatic logic [53:0] dut_entry();
    return {bus.out_pc, bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt, bus.out_imm8,
            bus.out_off9, bus.out_cond, bus.out_wmem_en, bus.out_wreg_en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_instr  = 16'h0;
    bus.in_pc     = 16'h0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [15:0] q_ins[$];
  logic [15:0] q_pc[$];
  logic [15:0] w;
  int n_dec, n_stall;
  bit hs, acc;

  initial begin
    do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_halted", bus.halted, 0);
    check("rst_out_fields", dut_entry(), 0);
    tick();
    rst_n = 1'b1;

    // ADD-class word with the consumer ready
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 16'h1234; bus.in_pc = 16'h0100;
    tick();
    check("add_valid", bus.out_valid, 1);
    check("add_fields", {bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt, bus.out_wreg_en},
          {4'h1, 4'h2, 4'h3, 4'h4, 1'b1});
    check("add_pc", bus.out_pc, 16'h0100);

    bus.in_instr = 16'h9A51; bus.in_pc = 16'h0102;
    tick();
    check("sw_fields", {bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_wmem_en, bus.out_wreg_en},
          {4'h9, 4'hA, 4'h5, 1'b1, 1'b0});

    bus.in_instr = 16'hC6FF; bus.in_pc = 16'h0104;
    tick();
    check("b_fields", {bus.out_opcode, bus.out_cond, bus.out_off9, bus.out_wreg_en, bus.out_wmem_en},
          {4'hC, 3'd3, 9'h0FF, 1'b0, 1'b0});

    bus.in_instr = 16'hE123; bus.in_pc = 16'h0106;
    tick();
    check("llb_wreg", {bus.out_rd, bus.out_imm8, bus.out_off9, bus.out_wreg_en}, {4'h1, 8'h23, 9'h0, 1'b1});
    bus.in_valid = 1'b0;
    tick();
    check("drained", bus.out_valid, 0);

    // Three back-to-back words into a stalled output
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 16'h1111; bus.in_pc = 16'h0010;
    tick();
    check("stall_first_rdy", bus.in_ready, 1);
    bus.in_instr = 16'h2222; bus.in_pc = 16'h0011;
    tick();
    check("stall_skid_full", bus.in_ready, 0);
    bus.in_instr = 16'h3333; bus.in_pc = 16'h0012;
    tick();
    check("stall_hold_pc", bus.out_pc, 16'h0010);
    tick();
    check("stall_hold_rdy", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    tick();
    check("drain_second", bus.out_pc, 16'h0011);
    check("drain_rdy", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("drain_third", {bus.out_valid, bus.out_pc, bus.out_opcode}, {1'b1, 16'h0012, 4'h3});
    tick();
    check("drain_empty", bus.out_valid, 0);

    // HLT blocks further input and sets halted on exit
    bus.in_valid = 1'b1; bus.in_instr = 16'hF000; bus.in_pc = 16'h0020;
    tick();
    bus.in_instr = 16'h1111; bus.in_pc = 16'h0021;
    check("hlt_rdy_low", bus.in_ready, 0);
    check("hlt_out", {bus.out_valid, bus.out_opcode, bus.halted}, {1'b1, 4'hF, 1'b0});
    tick();
    check("hlt_halted", bus.halted, 1);
    check("hlt_no_next", bus.out_valid, 0);
    tick();
    tick();
    check("hlt_never_accepted", {bus.out_valid, bus.in_ready}, {1'b0, 1'b0});
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("hlt_flush_sticky", {bus.halted, bus.in_ready}, {1'b1, 1'b1});

    // Flush with both registers full and a HLT pending
    do_reset();
    bus.in_valid = 1'b1; bus.in_instr = 16'h1234; bus.in_pc = 16'h0030;
    tick();
    bus.in_instr = 16'hF000; bus.in_pc = 16'h0031;
    tick();
    check("flush_pre_rdy", bus.in_ready, 0);
    bus.flush = 1'b1; bus.in_instr = 16'h2222;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_state", {bus.out_valid, bus.in_ready, bus.halted}, {1'b0, 1'b1, 1'b0});
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.in_instr = 16'h3333;
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush_drops_input", bus.out_valid, 0);
    tick();
    check("flush_stays_empty", bus.out_valid, 0);

    // Random traffic against a queue model of the held entries
    do_reset();
    n_dec = 0; n_stall = 0;
    for (int c = 0; c < 800; c++) begin
      tick();
      check("rnd_out_valid", bus.out_valid, q_ins.size() > 0);
      check("rnd_in_ready", bus.in_ready, q_ins.size() < 2);
      if (q_ins.size() > 0) check("rnd_entry", dut_entry(), {q_pc[0], ref_dec(q_ins[0])});
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = w;
      bus.in_pc     = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 29) == 0);
      hs  = (q_ins.size() > 0) && bus.out_ready;
      acc = bus.in_valid && (q_ins.size() < 2) && !bus.flush;
      if (q_ins.size() > 0 && !bus.out_ready) n_stall++;
      if (hs) begin
        n_dec++;
        void'(q_ins.pop_front());
        void'(q_pc.pop_front());
      end
      if (bus.flush) begin
        q_ins.delete();
        q_pc.delete();
      end else if (acc) begin
        q_ins.push_back(w);
        q_pc.push_back(bus.in_pc);
      end
    end
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    check("rnd_halted", bus.halted, 0);
`ifdef DECODE_PERF_CNT_EN
    check("perf_decoded", perf_decoded, n_dec);
    check("perf_stall", perf_stall, n_stall);
`endif

    // Asynchronous reset in the middle of a stall
    do_reset();
    bus.in_valid = 1'b1; bus.in_instr = 16'h1234; bus.in_pc = 16'h0040;
    tick();
    bus.in_pc = 16'h0041;
    tick();
    bus.in_valid = 1'b0;
    check("prereset_stalled", {bus.out_valid, bus.in_ready}, {1'b1, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", {bus.out_valid, bus.in_ready, bus.halted}, {1'b0, 1'b1, 1'b0});
    check("async_rst_fields", dut_entry(), 0);
`ifdef DECODE_PERF_CNT_EN
    check("async_rst_perf", {perf_decoded, perf_stall}, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_empty", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
